// File: rtl/mux_tristate_if.sv
// Bus bundle for mux_tristate: data inputs, select, resolved output,
// registered output and select-change counter.
`timescale 1ns/1ps
interface mux_tristate_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_q;
  logic [CNT_W-1:0] sel_cnt;

  modport master (
    output a, b, sel,
    input  dout, dout_q, sel_cnt
  );

  modport slave (
    input  a, b, sel,
    output dout, dout_q, sel_cnt
  );
endinterface

// File: rtl/mux_tristate.sv
// 2:1 mux from two complementary-enabled tristate drivers on a shared net,
// plus a registered copy of the output and a saturating select-change counter.
`timescale 1ns/1ps
module mux_tristate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           reset,
  mux_tristate_if.slave bus
);

  // Shared resolved net; exactly one driver is enabled for a known select,
  // and an unknown select yields X through both drivers.
  tri [WIDTH-1:0] dout_net;

  assign dout_net = (bus.sel == 1'b0) ? bus.a : 'z;
  assign dout_net = (bus.sel == 1'b1) ? bus.b : 'z;

  assign bus.dout = dout_net;

  logic [WIDTH-1:0] dout_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sel_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r   <= '0;
      cnt_r    <= '0;
      sel_prev <= 1'b0;
    end else begin
      dout_r   <= dout_net;
      sel_prev <= bus.sel;
      if ((bus.sel != sel_prev) && (cnt_r != '1))
        cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.dout_q  = dout_r;
  assign bus.sel_cnt = cnt_r;

endmodule

// File: tb/tb_mux_tristate.sv
// Randomized self-checking bench for mux_tristate against a behavioural model.
`timescale 1ns/1ps
module tb_mux_tristate;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   run   = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mux_tristate_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  mux_tristate #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 if (run) clk = ~clk;

  // Reference: last sampled output and a plain count of observed select changes.
  logic [W-1:0] m_q;
  int unsigned  m_changes;
  logic         m_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q       = '0;
      m_changes = 0;
      m_prev    = 1'b0;
    end else begin
      if (bus.sel !== m_prev) m_changes = m_changes + 1;
      m_prev = bus.sel;
      m_q    = bus.sel ? bus.b : bus.a;
    end
  end

  function automatic logic [W-1:0] exp_dout();
    return bus.sel ? bus.b : bus.a;
  endfunction

  function automatic logic [31:0] exp_cnt();
    return (m_changes > CNT_MAX) ? CNT_MAX : m_changes;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".dout_q"}, 32'(bus.dout_q), 32'(m_q));
    check({tag, ".sel_cnt"}, 32'(bus.sel_cnt), exp_cnt());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   vec [5];
    logic [W-1:0] req [5];
    vec = '{3'b000, 3'b100, 3'b101, 3'b011, 3'b000};
    req = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};

    bus.a = '0; bus.b = '0; bus.sel = 1'b0;

    // No clock, reset low: combinational truth table
    for (int i = 0; i < 5; i++) begin
      bus.a   = W'(vec[i][2]);
      bus.b   = W'(vec[i][1]);
      bus.sel = vec[i][0];
      #1;
      check($sformatf("comb%0d", i), 32'(bus.dout), 32'(req[i]));
      #999;
    end

    // Reset with no clock: registers clear immediately
    reset = 1'b1;
    #1;
    check_regs("rst_noclk");
    check("rst_noclk.q0", 32'(bus.dout_q), 32'h0);

    // Wide data while reset is held, then released
    bus.a = 8'hA5; bus.b = 8'h3C; bus.sel = 1'b0;
    #1 check("wide_sel0_rst", 32'(bus.dout), 32'hA5);
    bus.sel = 1'b1;
    #1 check("wide_sel1_rst", 32'(bus.dout), 32'h3C);
    reset = 1'b0;
    bus.sel = 1'b0;
    #1 check("wide_sel0", 32'(bus.dout), 32'hA5);
    bus.sel = 1'b1;
    #1 check("wide_sel1", 32'(bus.dout), 32'h3C);

    // Random combinational sweep, no clock
    for (int i = 0; i < 40; i++) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.sel = 1'($urandom);
      #1;
      check("sweep.dout", 32'(bus.dout), 32'(exp_dout()));
      check("sweep.known", 32'($isunknown(bus.dout)), 32'h0);
    end

    // Clocked path
    reset = 1'b1; #2 reset = 1'b0;
    bus.a = 8'd1; bus.b = 8'd0; bus.sel = 1'b0;
    run = 1'b1;
    tick();
    check("clk.q_after_edge", 32'(bus.dout_q), 32'h1);
    check_regs("clk1");
    bus.sel = 1'b1;
    #1;
    check("clk.dout_imm", 32'(bus.dout), 32'h0);
    check("clk.q_holds", 32'(bus.dout_q), 32'h1);
    tick();
    check("clk.q_next", 32'(bus.dout_q), 32'h0);
    check_regs("clk2");

    // Async reset between edges with dout_q=1, sel_cnt=3
    #2 reset = 1'b1; #1 reset = 1'b0;
    bus.a = 8'd1; bus.b = 8'd1;
    bus.sel = 1'b1; tick();
    check("first_sel1_counts", 32'(bus.sel_cnt), 32'h1);
    bus.sel = 1'b0; tick();
    bus.sel = 1'b1; tick();
    check("pre_rst.q", 32'(bus.dout_q), 32'h1);
    check("pre_rst.cnt", 32'(bus.sel_cnt), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("async_rst.q", 32'(bus.dout_q), 32'h0);
    check("async_rst.cnt", 32'(bus.sel_cnt), 32'h0);
    bus.a = 8'h5A; bus.b = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      bus.sel = ~bus.sel;
      #1 check("rst_track.dout", 32'(bus.dout), 32'(exp_dout()));
      tick();
      check_regs("rst_hold");
    end
    reset = 1'b0;
    bus.sel = 1'b0;

    // Saturation: toggle every cycle for 300 cycles
    #2 reset = 1'b1; #1 reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.sel = ~bus.sel;
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      tick();
      check_regs("sat");
    end
    check("sat.final", 32'(bus.sel_cnt), 32'(CNT_MAX));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold.cnt", 32'(bus.sel_cnt), 32'(CNT_MAX));
    end

    // Random operation with occasional mid-cycle resets
    for (int i = 0; i < 200; i++) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.sel = ($urandom_range(0, 3) == 0) ? ~bus.sel : bus.sel;
      #1 check("rand.dout", 32'(bus.dout), 32'(exp_dout()));
      if ($urandom_range(0, 19) == 0) begin
        #1 reset = 1'b1;
        #1 check_regs("rand_rst");
        reset = 1'b0;
      end
      tick();
      check_regs("rand");
    end

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
